// File: rtl/sump_cmd_parser_if.sv
// Byte stream from the UART receiver into the SUMP command parser.
// The receiver drives the byte strobe and data; the parser only listens.
interface sump_cmd_parser_if;
  logic       rx_stb_i;
  logic [7:0] rx_data_i;

  modport master (output rx_stb_i, output rx_data_i);
  modport slave  (input  rx_stb_i, input  rx_data_i);
endinterface

// File: rtl/sump_cmd_parser.sv
// SUMP command parser: assembles short (1 byte) and long (opcode + 4 bytes)
// commands from the UART byte stream and turns each completed command into a
// registered one-cycle strobe, a 32-bit argument and a trigger stage index.
// Also owns the XON/XOFF transmit-enable level and drops a half-received long
// command when the gap between its bytes grows too long.
module sump_cmd_parser #(
  parameter int  NUM_STAGES     = 4,
  parameter int  TIMEOUT_CYCLES = 100000,
  localparam int STG_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sump_cmd_parser_if.slave  rx,
  output logic              sft_rst_o,
  output logic              armd_o,
  output logic              id_o,
  output logic              xon_o,
  output logic              xoff_o,
  output logic              tx_en_o,
  output logic              set_mask_o,
  output logic              set_val_o,
  output logic              set_cfg_o,
  output logic              set_div_o,
  output logic              set_cnt_o,
  output logic              set_flgs_o,
  output logic              stb_o,
  output logic [STG_W-1:0]  stg_o,
  output logic [31:0]       cmd_o,
  output logic              err_o
);

  localparam int              TO_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      STG_LIMIT = 3'(NUM_STAGES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ARG  = 1'b1
  } state_t;

  state_t          state_r;
  logic [7:0]      opc_r;
  logic [23:0]     arg_r;
  logic [1:0]      arg_cnt_r;
  logic [TO_W-1:0] to_cnt_r;

  logic [31:0]     arg_full_s;
  logic [TO_W-1:0] to_cnt_inc_s;
  logic [1:0]      stage_s;
  logic            stage_ok_s;
  logic            to_expire_s;

  // Assembled argument, stage range check and inter-byte timeout detection.
  always_comb begin
    arg_full_s   = {rx.rx_data_i, arg_r};
    to_cnt_inc_s = to_cnt_r + TO_W'(1);
    stage_s      = opc_r[3:2];
    stage_ok_s   = ({1'b0, stage_s} < STG_LIMIT);
    // An arriving byte always beats an expiring counter.
    if ((TIMEOUT_CYCLES != 0) && (state_r == ARG) && !rx.rx_stb_i &&
        (to_cnt_inc_s == TO_LIMIT)) begin
      to_expire_s = 1'b1;
    end else begin
      to_expire_s = 1'b0;
    end
  end

  // Command FSM with registered strobes, argument, stage and tx enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      opc_r      <= 8'h00;
      arg_r      <= 24'h000000;
      arg_cnt_r  <= 2'd0;
      to_cnt_r   <= '0;
      sft_rst_o  <= 1'b0;
      armd_o     <= 1'b0;
      id_o       <= 1'b0;
      xon_o      <= 1'b0;
      xoff_o     <= 1'b0;
      tx_en_o    <= 1'b1;
      set_mask_o <= 1'b0;
      set_val_o  <= 1'b0;
      set_cfg_o  <= 1'b0;
      set_div_o  <= 1'b0;
      set_cnt_o  <= 1'b0;
      set_flgs_o <= 1'b0;
      stb_o      <= 1'b0;
      stg_o      <= '0;
      cmd_o      <= 32'h0000_0000;
      err_o      <= 1'b0;
    end else begin
      // Every strobe is a single-cycle pulse unless re-asserted below.
      sft_rst_o  <= 1'b0;
      armd_o     <= 1'b0;
      id_o       <= 1'b0;
      xon_o      <= 1'b0;
      xoff_o     <= 1'b0;
      set_mask_o <= 1'b0;
      set_val_o  <= 1'b0;
      set_cfg_o  <= 1'b0;
      set_div_o  <= 1'b0;
      set_cnt_o  <= 1'b0;
      set_flgs_o <= 1'b0;
      stb_o      <= 1'b0;
      err_o      <= 1'b0;

      case (state_r)
        IDLE: begin
          to_cnt_r <= '0;
          if (rx.rx_stb_i) begin
            if (rx.rx_data_i[7]) begin
              opc_r     <= rx.rx_data_i;
              arg_cnt_r <= 2'd0;
              state_r   <= ARG;
            end else begin
              case (rx.rx_data_i)
                8'h00: begin sft_rst_o <= 1'b1; stb_o <= 1'b1; end
                8'h01: begin armd_o    <= 1'b1; stb_o <= 1'b1; end
                8'h02: begin id_o      <= 1'b1; stb_o <= 1'b1; end
                8'h11: begin xon_o  <= 1'b1; stb_o <= 1'b1; tx_en_o <= 1'b1; end
                8'h13: begin xoff_o <= 1'b1; stb_o <= 1'b1; tx_en_o <= 1'b0; end
                default: err_o <= 1'b1;
              endcase
            end
          end
        end

        ARG: begin
          if (rx.rx_stb_i) begin
            to_cnt_r <= '0;
            if (arg_cnt_r == 2'd3) begin
              // Fourth argument byte: decode the whole command now.
              state_r   <= IDLE;
              arg_cnt_r <= 2'd0;
              case (opc_r)
                8'h80: begin set_div_o  <= 1'b1; stb_o <= 1'b1; cmd_o <= arg_full_s; stg_o <= '0; end
                8'h81: begin set_cnt_o  <= 1'b1; stb_o <= 1'b1; cmd_o <= arg_full_s; stg_o <= '0; end
                8'h82: begin set_flgs_o <= 1'b1; stb_o <= 1'b1; cmd_o <= arg_full_s; stg_o <= '0; end
                8'hC0, 8'hC4, 8'hC8, 8'hCC: begin
                  if (stage_ok_s) begin
                    set_mask_o <= 1'b1; stb_o <= 1'b1;
                    cmd_o <= arg_full_s; stg_o <= STG_W'(stage_s);
                  end else begin
                    err_o <= 1'b1;
                  end
                end
                8'hC1, 8'hC5, 8'hC9, 8'hCD: begin
                  if (stage_ok_s) begin
                    set_val_o <= 1'b1; stb_o <= 1'b1;
                    cmd_o <= arg_full_s; stg_o <= STG_W'(stage_s);
                  end else begin
                    err_o <= 1'b1;
                  end
                end
                8'hC2, 8'hC6, 8'hCA, 8'hCE: begin
                  if (stage_ok_s) begin
                    set_cfg_o <= 1'b1; stb_o <= 1'b1;
                    cmd_o <= arg_full_s; stg_o <= STG_W'(stage_s);
                  end else begin
                    err_o <= 1'b1;
                  end
                end
                default: err_o <= 1'b1;
              endcase
            end else begin
              // Little-endian: first argument byte lands in the low byte.
              case (arg_cnt_r)
                2'd0:    arg_r[7:0]   <= rx.rx_data_i;
                2'd1:    arg_r[15:8]  <= rx.rx_data_i;
                2'd2:    arg_r[23:16] <= rx.rx_data_i;
                default: arg_r        <= arg_r;
              endcase
              arg_cnt_r <= arg_cnt_r + 2'd1;
            end
          end else if (to_expire_s) begin
            state_r   <= IDLE;
            arg_cnt_r <= 2'd0;
            to_cnt_r  <= '0;
            err_o     <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            to_cnt_r <= to_cnt_inc_s;
          end else begin
            to_cnt_r <= '0;
          end
        end

        default: begin
          state_r   <= IDLE;
          arg_cnt_r <= 2'd0;
          to_cnt_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Directed self-checking bench for sump_cmd_parser. Two instances share one
// byte stream: one with 4 trigger stages, one with 2, both with a 10-cycle
// inter-byte timeout.
module tb_sump_cmd_parser;

  // Observation vector bit order:
  // {sft, armd, id, xon, xoff, mask, val, cfg, div, cnt, flgs, stb, err, tx_en}
  localparam logic [13:0] O_SFT  = 14'h2000;
  localparam logic [13:0] O_ARMD = 14'h1000;
  localparam logic [13:0] O_ID   = 14'h0800;
  localparam logic [13:0] O_XON  = 14'h0400;
  localparam logic [13:0] O_XOFF = 14'h0200;
  localparam logic [13:0] O_MASK = 14'h0100;
  localparam logic [13:0] O_VAL  = 14'h0080;
  localparam logic [13:0] O_CNT  = 14'h0010;
  localparam logic [13:0] O_DIV  = 14'h0020;
  localparam logic [13:0] O_STB  = 14'h0004;
  localparam logic [13:0] O_ERR  = 14'h0002;
  localparam logic [13:0] O_TX   = 14'h0001;

  logic clk = 1'b0;
  logic rst_i;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sump_cmd_parser_if rx_if ();

  logic        sft4, armd4, id4, xon4, xoff4, txen4, mask4, val4, cfg4, div4, cnt4, flgs4, stb4, err4;
  logic [1:0]  stg4;
  logic [31:0] cmd4;
  logic        sft2, armd2, id2, xon2, xoff2, txen2, mask2, val2, cfg2, div2, cnt2, flgs2, stb2, err2;
  logic [0:0]  stg2;
  logic [31:0] cmd2;
  logic [13:0] o4, o2;

  assign o4 = {sft4, armd4, id4, xon4, xoff4, mask4, val4, cfg4, div4, cnt4, flgs4, stb4, err4, txen4};
  assign o2 = {sft2, armd2, id2, xon2, xoff2, mask2, val2, cfg2, div2, cnt2, flgs2, stb2, err2, txen2};

  sump_cmd_parser #(.NUM_STAGES(4), .TIMEOUT_CYCLES(10)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .rx(rx_if),
    .sft_rst_o(sft4), .armd_o(armd4), .id_o(id4), .xon_o(xon4), .xoff_o(xoff4),
    .tx_en_o(txen4), .set_mask_o(mask4), .set_val_o(val4), .set_cfg_o(cfg4),
    .set_div_o(div4), .set_cnt_o(cnt4), .set_flgs_o(flgs4), .stb_o(stb4),
    .stg_o(stg4), .cmd_o(cmd4), .err_o(err4)
  );

  sump_cmd_parser #(.NUM_STAGES(2), .TIMEOUT_CYCLES(10)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .rx(rx_if),
    .sft_rst_o(sft2), .armd_o(armd2), .id_o(id2), .xon_o(xon2), .xoff_o(xoff2),
    .tx_en_o(txen2), .set_mask_o(mask2), .set_val_o(val2), .set_cfg_o(cfg2),
    .set_div_o(div2), .set_cnt_o(cnt2), .set_flgs_o(flgs2), .stb_o(stb2),
    .stg_o(stg2), .cmd_o(cmd2), .err_o(err2)
  );

  // Present one byte (or an idle cycle) for exactly one rising edge; returns on
  // the following falling edge, where outputs reflect that edge.
  task automatic drive(input logic s, input logic [7:0] d);
    rx_if.rx_stb_i  = s;
    rx_if.rx_data_i = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    rst_i = 1'b0;
    n_cmp++; if (o4 !== O_TX) begin n_fail++; $display("FAIL reset_o4: got %h want %h", o4, O_TX); end
    n_cmp++; if (cmd4 !== 32'h0) begin n_fail++; $display("FAIL reset_cmd4: got %h want 0", cmd4); end
    n_cmp++; if (stg4 !== 2'd0) begin n_fail++; $display("FAIL reset_stg4: got %h want 0", stg4); end
    n_cmp++; if (o2 !== O_TX) begin n_fail++; $display("FAIL reset_o2: got %h want %h", o2, O_TX); end
    n_cmp++; if (cmd2 !== 32'h0) begin n_fail++; $display("FAIL reset_cmd2: got %h want 0", cmd2); end
  endtask

  task automatic test_short_b2b;
    logic        s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  b [4] = '{8'h02, 8'h01, 8'h00, 8'h00};
    logic [13:0] e [4] = '{O_ID | O_STB | O_TX, O_ARMD | O_STB | O_TX, O_SFT | O_STB | O_TX, O_TX};
    for (int i = 0; i < 4; i++) begin
      drive(s[i], b[i]);
      n_cmp++;
      if (o4 !== e[i]) begin n_fail++; $display("FAIL short_b2b[%0d]: got %h want %h", i, o4, e[i]); end
    end
  endtask

  typedef struct packed {
    logic        s;
    logic [7:0]  d;
    logic [13:0] e4;
    logic [13:0] e2;
    logic [31:0] c4;
    logic [31:0] c2;
    logic [1:0]  g4;
    logic        g2;
  } step_t;

  task automatic test_long;
    step_t t [21];
    t[0]  = '{1'b1, 8'hC4, O_TX, O_TX, 32'h0, 32'h0, 2'd0, 1'b0};
    t[1]  = '{1'b1, 8'h78, O_TX, O_TX, 32'h0, 32'h0, 2'd0, 1'b0};
    t[2]  = '{1'b1, 8'h56, O_TX, O_TX, 32'h0, 32'h0, 2'd0, 1'b0};
    t[3]  = '{1'b1, 8'h34, O_TX, O_TX, 32'h0, 32'h0, 2'd0, 1'b0};
    t[4]  = '{1'b1, 8'h12, O_MASK | O_STB | O_TX, O_MASK | O_STB | O_TX, 32'h12345678, 32'h12345678, 2'd1, 1'b1};
    t[5]  = '{1'b1, 8'hCD, O_TX, O_TX, 32'h12345678, 32'h12345678, 2'd1, 1'b1};
    t[6]  = '{1'b1, 8'hAA, O_TX, O_TX, 32'h12345678, 32'h12345678, 2'd1, 1'b1};
    t[7]  = '{1'b1, 8'hBB, O_TX, O_TX, 32'h12345678, 32'h12345678, 2'd1, 1'b1};
    t[8]  = '{1'b1, 8'hCC, O_TX, O_TX, 32'h12345678, 32'h12345678, 2'd1, 1'b1};
    t[9]  = '{1'b1, 8'hDD, O_VAL | O_STB | O_TX, O_ERR | O_TX, 32'hDDCCBBAA, 32'h12345678, 2'd3, 1'b1};
    t[10] = '{1'b1, 8'h81, O_TX, O_TX, 32'hDDCCBBAA, 32'h12345678, 2'd3, 1'b1};
    t[11] = '{1'b1, 8'h01, O_TX, O_TX, 32'hDDCCBBAA, 32'h12345678, 2'd3, 1'b1};
    t[12] = '{1'b1, 8'h00, O_TX, O_TX, 32'hDDCCBBAA, 32'h12345678, 2'd3, 1'b1};
    t[13] = '{1'b1, 8'h02, O_TX, O_TX, 32'hDDCCBBAA, 32'h12345678, 2'd3, 1'b1};
    t[14] = '{1'b1, 8'h00, O_CNT | O_STB | O_TX, O_CNT | O_STB | O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    t[15] = '{1'b1, 8'h83, O_TX, O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    t[16] = '{1'b1, 8'h11, O_TX, O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    t[17] = '{1'b1, 8'h13, O_TX, O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    t[18] = '{1'b1, 8'h00, O_TX, O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    t[19] = '{1'b1, 8'h01, O_ERR | O_TX, O_ERR | O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    t[20] = '{1'b0, 8'h00, O_TX, O_TX, 32'h00020001, 32'h00020001, 2'd0, 1'b0};
    for (int i = 0; i < 21; i++) begin
      drive(t[i].s, t[i].d);
      n_cmp++; if (o4 !== t[i].e4) begin n_fail++; $display("FAIL long_o4[%0d]: got %h want %h", i, o4, t[i].e4); end
      n_cmp++; if (o2 !== t[i].e2) begin n_fail++; $display("FAIL long_o2[%0d]: got %h want %h", i, o2, t[i].e2); end
      n_cmp++; if (cmd4 !== t[i].c4) begin n_fail++; $display("FAIL long_cmd4[%0d]: got %h want %h", i, cmd4, t[i].c4); end
      n_cmp++; if (cmd2 !== t[i].c2) begin n_fail++; $display("FAIL long_cmd2[%0d]: got %h want %h", i, cmd2, t[i].c2); end
      n_cmp++; if (stg4 !== t[i].g4) begin n_fail++; $display("FAIL long_stg4[%0d]: got %h want %h", i, stg4, t[i].g4); end
      n_cmp++; if (stg2 !== t[i].g2) begin n_fail++; $display("FAIL long_stg2[%0d]: got %h want %h", i, stg2, t[i].g2); end
    end
  endtask

  task automatic test_xon_xoff;
    // Masked compare: the repeated XOFF only pins the tx_en level.
    logic [7:0]  b [6] = '{8'h13, 8'h13, 8'h00, 8'h11, 8'h05, 8'h00};
    logic        s [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [13:0] e [6] = '{O_XOFF | O_STB, O_XOFF | O_STB, O_SFT | O_STB,
                           O_XON | O_STB | O_TX, O_ERR | O_TX, O_TX};
    logic [13:0] m [6] = '{14'h3FFF, 14'h0001, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF};
    for (int i = 0; i < 6; i++) begin
      drive(s[i], b[i]);
      n_cmp++;
      if ((o4 & m[i]) !== (e[i] & m[i])) begin
        n_fail++; $display("FAIL xon_xoff[%0d]: got %h want %h (mask %h)", i, o4, e[i], m[i]);
      end
    end
  endtask

  task automatic test_timeout;
    drive(1'b1, 8'h80);
    drive(1'b1, 8'h01);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 8'h00);
      n_cmp++; if (o4 !== O_TX) begin n_fail++; $display("FAIL to_wait[%0d]: got %h want %h", i, o4, O_TX); end
    end
    drive(1'b0, 8'h00);
    n_cmp++; if (o4 !== (O_ERR | O_TX)) begin n_fail++; $display("FAIL to_expire: got %h want %h", o4, O_ERR | O_TX); end
    drive(1'b0, 8'h00);
    n_cmp++; if (o4 !== O_TX) begin n_fail++; $display("FAIL to_err_pulse: got %h want %h", o4, O_TX); end
    drive(1'b1, 8'h02);
    n_cmp++; if (o4 !== (O_ID | O_STB | O_TX)) begin n_fail++; $display("FAIL to_resync: got %h want %h", o4, O_ID | O_STB | O_TX); end
    // Same again, but the next byte arrives exactly in the expiry cycle.
    drive(1'b1, 8'h80);
    drive(1'b1, 8'h01);
    for (int i = 0; i < 9; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'h02);
    n_cmp++; if (o4 !== O_TX) begin n_fail++; $display("FAIL to_edge_byte: got %h want %h", o4, O_TX); end
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    n_cmp++; if (o4 !== (O_DIV | O_STB | O_TX)) begin n_fail++; $display("FAIL to_edge_div: got %h want %h", o4, O_DIV | O_STB | O_TX); end
    n_cmp++; if (cmd4 !== 32'h04030201) begin n_fail++; $display("FAIL to_edge_cmd: got %h want 04030201", cmd4); end
    n_cmp++; if (stg4 !== 2'd0) begin n_fail++; $display("FAIL to_edge_stg: got %h want 0", stg4); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 8'h82);
    drive(1'b1, 8'h11);
    rst_i = 1'b1;
    drive(1'b0, 8'h00);
    rst_i = 1'b0;
    n_cmp++; if (o4 !== O_TX) begin n_fail++; $display("FAIL rmid_reset: got %h want %h", o4, O_TX); end
    n_cmp++; if (cmd4 !== 32'h0) begin n_fail++; $display("FAIL rmid_cmd: got %h want 0", cmd4); end
    drive(1'b1, 8'h01);
    n_cmp++; if (o4 !== (O_ARMD | O_STB | O_TX)) begin n_fail++; $display("FAIL rmid_armd: got %h want %h", o4, O_ARMD | O_STB | O_TX); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00);
      n_cmp++; if (o4 !== O_TX) begin n_fail++; $display("FAIL rmid_quiet[%0d]: got %h want %h", i, o4, O_TX); end
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    rx_if.rx_stb_i  = 1'b0;
    rx_if.rx_data_i = 8'h00;
    @(negedge clk);
    test_reset();
    test_short_b2b();
    test_long();
    test_xon_xoff();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sump_cmd_parser.md
Name: sump_cmd_parser

Overview:
- Parametrised successor to the SUMP instruction decoder.
- Consumes the raw byte stream from the UART receiver and assembles SUMP short commands (1 byte) and long commands (opcode plus 4 argument bytes).
- Decodes each completed command into registered one-hot strobes, a 32-bit argument and a stage index; owns the XON/XOFF transmit-enable state.
- Sits between the UART RX and the trigger, sampler and config registers; it re-synchronises to the stream on inter-byte timeout.

Parameters:
NUM_STAGES, 4, number of trigger stages addressed by long opcodes (1..4); the stage field is opcode bits [3:2].
TIMEOUT_CYCLES, 100000, clk_i cycles allowed between argument bytes before the partial command is dropped; 0 disables the timeout.
STG_W, $clog2(NUM_STAGES) with a minimum of 1, width of stg_o (derived, not overridable).

Ports:
clk_i  input  1  system clock, all logic on the rising edge
rst_i  input  1  reset, synchronous, active-high
rx_stb_i  input  1  one-cycle strobe: rx_data_i holds a valid byte
rx_data_i  input  8  received byte
sft_rst_o  output  1  pulse: soft reset (0x00)
armd_o  output  1  pulse: run/arm (0x01)
id_o  output  1  pulse: ID request (0x02)
xon_o  output  1  pulse: XON (0x11)
xoff_o  output  1  pulse: XOFF (0x13)
tx_en_o  output  1  level: transmitter permitted to send
set_mask_o  output  1  pulse: 0xC0 | stg<<2
set_val_o  output  1  pulse: 0xC1 | stg<<2
set_cfg_o  output  1  pulse: 0xC2 | stg<<2
set_div_o  output  1  pulse: 0x80
set_cnt_o  output  1  pulse: 0x81
set_flgs_o  output  1  pulse: 0x82
stb_o  output  1  pulse: any valid command strobe asserted this cycle
stg_o  output  STG_W  stage index, valid with stb_o
cmd_o  output  32  argument of the last long command, valid with stb_o, held until next long command
err_o  output  1  pulse: unknown opcode, out-of-range stage, or timeout

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All pulse outputs are 0; cmd_o=0, stg_o=0, tx_en_o=1.
  - FSM goes to IDLE, the argument counter and the timeout counter clear, and any partial command is discarded.
- FSM states: IDLE, ARG.
- IDLE:
  - On rx_stb_i with rx_data_i[7]=0 (short command): decode the byte. The strobe appears on the cycle after the byte strobe (latency 1), and the FSM stays in IDLE.
  - On rx_stb_i with rx_data_i[7]=1 (long command): latch the opcode, clear the argument counter, go to ARG.
- ARG:
  - Each rx_stb_i shifts the byte in little-endian order: the first argument byte goes to cmd[7:0], the fourth to cmd[31:24].
  - When the 4th byte is accepted, decode. The strobe, the new cmd_o and stg_o all appear on the next cycle (latency 1 after the 4th byte), and the FSM returns to IDLE.
  - Every argument byte is treated as data, including 0x00, 0x11 and 0x13.
- Timeout:
  - The timeout counter runs only in ARG and resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES with no byte, the partial command is dropped, err_o pulses for 1 cycle and the FSM goes to IDLE.
  - If rx_stb_i arrives in the expiry cycle, the byte wins: it is accepted and no timeout occurs.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Decode rules:
  - Short opcodes: 0x00, 0x01, 0x02, 0x11, 0x13. Any other byte with bit 7 clear gives err_o and no strobe.
  - Long opcodes: 0x80, 0x81, 0x82, and 0xC0/0xC1/0xC2 with bits [3:2] giving the stage.
  - Any other long opcode still consumes 4 argument bytes, then gives err_o; cmd_o is not updated.
  - Stage field >= NUM_STAGES: err_o is raised instead of the strobe, and cmd_o/stg_o are not updated.
- Strobe and error outputs:
  - Strobe outputs are registered, and at most one is high per cycle.
  - stb_o = OR of all strobes (xon_o and xoff_o included). err_o never coincides with stb_o.
- tx_en_o:
  - Cleared on the cycle xoff_o pulses, set on the cycle xon_o pulses.
  - Repeated XOFF or XON has no further effect.
  - sft_rst_o does not modify tx_en_o.
- Back-to-back bytes: rx_stb_i may be high on consecutive cycles. No byte is ever dropped, and decode never stalls the input.
- stg_o for non-staged commands (0x80–0x82) is 0.
- Formal: $onehot0 of all strobes together with err_o, every cycle.

Test Plan:
- Reset, then bytes 0x02, 0x01, 0x00 on consecutive cycles -> id_o, armd_o, sft_rst_o pulse on consecutive cycles, each 1 cycle after its byte; tx_en_o=1 throughout.
- Bytes 0xC4, 0x78, 0x56, 0x34, 0x12 with NUM_STAGES=4 -> set_mask_o and stb_o 1 cycle after 0x12; stg_o=1, cmd_o=0x12345678.
- NUM_STAGES=2; bytes 0xCD, 0xAA, 0xBB, 0xCC, 0xDD -> err_o pulse, no strobe, cmd_o keeps its previous value. Then 0x81, 0x01, 0x00, 0x02, 0x00 -> set_cnt_o, cmd_o=0x00020001, stg_o=0.
- Byte 0x13 -> xoff_o, tx_en_o=0. Then 0x13 -> tx_en_o stays 0. Then 0x11 -> xon_o, tx_en_o=1. Then 0x05 -> err_o only.
- TIMEOUT_CYCLES=10; bytes 0x80, 0x01, then idle 10 cycles -> err_o pulse and return to IDLE. Then 0x02 -> id_o, not treated as an argument. Repeat with the next byte landing exactly in the expiry cycle -> byte accepted, no err_o.
- Bytes 0x82, 0x11 -> assert rst_i -> send 0x01 -> armd_o only; no set_flgs_o or xon_o ever fires.
